// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues fetches under a credit limit, tracks
// in-flight addresses and buffers returned words for decode; flush-aware.
module ifetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   stale;
    logic [CW-1:0]   occ;
    logic [AW-1:0]   pc_wp;
    logic [AW-1:0]   pc_rp;
    logic [AW-1:0]   iq_wp;
    logic [AW-1:0]   iq_rp;
    logic [XLEN-1:0] pcq      [DEPTH];
    logic [XLEN-1:0] iq_pc    [DEPTH];
    logic [XLEN-1:0] iq_instr [DEPTH];

    logic credit;
    logic rsp_ok;
    logic keep;
    logic out_fire;

    // Credit looks only at registered counts so pc_ready has no path
    // from the response or decode side.
    assign credit = ({1'b0, outstanding} + {1'b0, occ}) < (CW+1)'(DEPTH);

    assign imem_req_valid = rst & pc_valid & credit & ~flush;
    assign imem_req_addr  = pc_in;
    assign pc_ready       = imem_req_valid & imem_req_ready;

    assign rsp_ok   = imem_rsp_valid & (outstanding != '0);
    assign keep     = rsp_ok & (stale == '0) & ~flush;
    assign out_valid = rst & (occ != '0) & ~flush;
    assign out_fire = out_valid & out_ready;

    assign out_instr = iq_instr[iq_rp];
    assign out_pc    = iq_pc[iq_rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            stale       <= '0;
            pc_wp       <= '0;
            pc_rp       <= '0;
        end else begin
            if (pc_ready)
                pc_wp <= pc_wp + 1'b1;
            if (rsp_ok)
                pc_rp <= pc_rp + 1'b1;

            if (pc_ready && !rsp_ok)
                outstanding <= outstanding + CW'(1);
            else if (!pc_ready && rsp_ok)
                outstanding <= outstanding - CW'(1);

            // A flush re-marks every fetch still in flight as stale.
            if (flush)
                stale <= rsp_ok ? outstanding - CW'(1) : outstanding;
            else if (rsp_ok && stale != '0)
                stale <= stale - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ   <= '0;
            iq_wp <= '0;
            iq_rp <= '0;
        end else if (flush) begin
            occ   <= '0;
            iq_rp <= iq_wp;
        end else begin
            if (keep)
                iq_wp <= iq_wp + 1'b1;
            if (out_fire)
                iq_rp <= iq_rp + 1'b1;
            if (keep && !out_fire)
                occ <= occ + CW'(1);
            else if (!keep && out_fire)
                occ <= occ - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pc_ready)
            pcq[pc_wp] <= pc_in;
        if (keep) begin
            iq_pc[iq_wp]    <= pcq[pc_rp];
            iq_instr[iq_wp] <= imem_rsp_data;
        end
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter: XLEN, 32, instruction/address width.
REQ-002 Parameter: DEPTH, 4, max in-flight plus buffered fetches (power of two, >=2).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pc_in  input  XLEN  fetch address from pc stage.
REQ-006 pc_valid  input  1  pc_in is valid.
REQ-007 pc_ready  output  1  address accepted this cycle; pc stage may load its next target.
REQ-008 imem_req_valid  output  1  fetch request to instruction memory.
REQ-009 imem_req_addr  output  XLEN  fetch address (equals pc_in).
REQ-010 imem_req_ready  input  1  memory accepts request.
REQ-011 imem_rsp_valid  input  1  instruction word returned, in request order, >=1 cycle after acceptance.
REQ-012 imem_rsp_data  input  XLEN  returned instruction word.
REQ-013 flush  input  1  redirect: discard all queued and in-flight fetches.
REQ-014 out_valid  output  1  instruction available to decode.
REQ-015 out_instr  output  XLEN  head instruction.
REQ-016 out_pc  output  XLEN  address of head instruction.
REQ-017 out_ready  input  1  decode consumes head.

Function
REQ-018 State: outstanding counter (0..DEPTH), stale counter (0..outstanding), pc FIFO of in-flight addresses, instr FIFO of {pc, instr} (DEPTH entries each).
REQ-019 credit = (outstanding + occupancy) < DEPTH, computed from registered state only; no combinational path from out_ready or imem_rsp_valid to pc_ready.
REQ-020 imem_req_valid = pc_valid & credit & !flush; imem_req_addr = pc_in.
REQ-021 pc_ready = imem_req_valid & imem_req_ready; on pc_ready, pc_in pushes into pc FIFO and outstanding increments.
REQ-022 On imem_rsp_valid, head of pc FIFO pops and outstanding decrements; simultaneous issue and response leaves outstanding unchanged.
REQ-023 Response with stale==0 and no flush: {popped pc, imem_rsp_data} pushes into instr FIFO; credit guarantees space.
REQ-024 Response with stale>0: data discarded, stale decrements.
REQ-025 out_valid = (occupancy != 0) & !flush; out_instr/out_pc = instr FIFO head.
REQ-026 Pop when out_valid & out_ready; push and pop in same cycle leave occupancy unchanged.
REQ-027 Flush cycle: instr FIFO emptied (occupancy=0); stale <= outstanding after this cycle's response decrement; response arriving in the flush cycle is discarded; no request issued.
REQ-028 Back-to-back flushes: each re-marks all remaining outstanding as stale; stale never exceeds outstanding.
REQ-029 FIFO pointers wrap modulo DEPTH; counters never overflow or underflow.
REQ-030 Response with outstanding==0 is a protocol error; it is ignored and changes no state.

Reset
REQ-031 rst low asynchronously clears outstanding, stale, occupancy, and all FIFO pointers; out_valid=0, imem_req_valid=0, pc_ready=0 while rst low.
REQ-032 FIFO data storage is not reset; out_instr/out_pc are don't-care while out_valid=0.
REQ-033 Reset asserted mid-operation drops all in-flight fetches; the bench does not return responses for them after release.

Verification
REQ-034 Streaming: pc_in 0x00,0x04,0x08, imem ready, 1-cycle latency, out_ready=1 -> out_pc 0x00,0x04,0x08 in order with matching words, one per cycle.
REQ-035 Backpressure: out_ready=0, imem always ready -> exactly 4 requests accepted, pc_ready=0 afterward; one pop -> one further request accepted the next cycle.
REQ-036 Flush in flight: 3 requests outstanding, flush pulse, then 3 responses 0xDEAD, new pc 0x40 -> the 0xDEAD words never appear; first out_pc=0x40.
REQ-037 Response coincident with flush: rsp 0x1234 in the flush cycle -> discarded, out_valid=0 that cycle, stale = remaining outstanding.
REQ-038 Async reset: rst low between clock edges with 2 queued and 1 outstanding -> out_valid=0 immediately; after release, pc_in 0x80 -> first out_pc=0x80.
REQ-039 imem_req_ready=0 for 5 cycles with pc_valid=1 -> pc_ready=0 throughout, pc_in held, no push into pc FIFO.
